// File: rtl/iq_mix_cic_decim.sv
// 1-bit RF x 1-bit LO mixer feeding two 3rd-order CIC decimators (I/Q) with a valid/ready output.
// Optional macro MIX_RF_SYNC_EN adds a 2-flop synchronizer on rf_in ahead of the rf_q register.
module iq_mix_cic_decim #(
   parameter int DECIM      = 256,
   parameter int DECIM_LOG2 = 8,
   parameter int ACC_W      = 26,
   parameter int OUT_W      = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rf_in,
   input  logic             sin_in,
   input  logic             cos_in,
   output logic [OUT_W-1:0] i_out,
   output logic [OUT_W-1:0] q_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun
);

   logic                       r_rf_q;
   logic [1:0][ACC_W-1:0]      w_prod;
   logic [1:0][ACC_W-1:0]      r_int1, r_int2, r_int3;
   logic [1:0][ACC_W-1:0]      r_x_d, r_c1, r_c1_d, r_c2, r_c2_d, r_c3;
   logic [DECIM_LOG2-1:0]      r_dcnt;
   logic                       r_tick, r_v1, r_v2, r_v3;

`ifdef MIX_RF_SYNC_EN
   logic [1:0] r_rf_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rf_sync <= '0;
         r_rf_q    <= 1'b0;
      end else begin
         r_rf_sync <= {r_rf_sync[0], rf_in};
         r_rf_q    <= r_rf_sync[1];
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) r_rf_q <= 1'b0;
      else     r_rf_q <= rf_in;
   end
`endif

   // Channel 0 = I (against cos), channel 1 = Q (against sin); +1 on match, -1 otherwise.
   always_comb begin
      w_prod[0] = (r_rf_q == cos_in) ? ACC_W'(1) : {ACC_W{1'b1}};
      w_prod[1] = (r_rf_q == sin_in) ? ACC_W'(1) : {ACC_W{1'b1}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_int1    <= '0;
         r_int2    <= '0;
         r_int3    <= '0;
         r_x_d     <= '0;
         r_c1      <= '0;
         r_c1_d    <= '0;
         r_c2      <= '0;
         r_c2_d    <= '0;
         r_c3      <= '0;
         r_dcnt    <= '0;
         r_tick    <= 1'b0;
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_v3      <= 1'b0;
         i_out     <= '0;
         q_out     <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         r_dcnt <= r_dcnt + 1'b1;
         r_tick <= (r_dcnt == DECIM_LOG2'(DECIM - 1));
         r_v1   <= r_tick;
         r_v2   <= r_v1;
         r_v3   <= r_v2;
         for (int ch = 0; ch < 2; ch++) begin
            r_int1[ch] <= r_int1[ch] + w_prod[ch];
            r_int2[ch] <= r_int2[ch] + r_int1[ch];
            r_int3[ch] <= r_int3[ch] + r_int2[ch];
            // r_int3 here already holds the value written on the tick edge.
            if (r_tick) begin
               r_c1[ch]  <= r_int3[ch] - r_x_d[ch];
               r_x_d[ch] <= r_int3[ch];
            end
            if (r_v1) begin
               r_c2[ch]   <= r_c1[ch] - r_c1_d[ch];
               r_c1_d[ch] <= r_c1[ch];
            end
            if (r_v2) begin
               r_c3[ch]   <= r_c2[ch] - r_c2_d[ch];
               r_c2_d[ch] <= r_c2[ch];
            end
         end
         if (r_v3) begin
            i_out <= r_c3[0][ACC_W-1 -: OUT_W];
            q_out <= r_c3[1][ACC_W-1 -: OUT_W];
         end
         // A sample still pending when the next lands is lost unless ready takes it this cycle.
         out_valid <= r_v3 | (out_valid & ~out_ready);
         overrun   <= r_v3 & out_valid & ~out_ready;
      end
   end

endmodule

// File: tb/tb_iq_mix_cic_decim.sv
// Self-checking bench for iq_mix_cic_decim: DC/tone vectors through a scoreboard,
// plus hand sequences for overrun, ready-on-overwrite and mid-period reset.
module tb_iq_mix_cic_decim;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rf_in = 1'b0, sin_in = 1'b0, cos_in = 1'b0;
   logic        out_ready = 1'b1;
   logic [11:0] i_out, q_out;
   logic        out_valid, overrun;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  edge_cnt = 0;
   bit  tog = 1'b0;

   typedef struct {
      bit          rf;
      bit          tg;
      bit          s;
      bit          c;
      logic [11:0] ei;
      logic [11:0] eq;
   } vec_t;

   typedef struct packed {
      logic [11:0] i;
      logic [11:0] q;
   } exp_t;

   vec_t vecs [4];
   exp_t sb [$];

`ifdef MIX_RF_SYNC_EN
   localparam int RF_LAT = 3;
`else
   localparam int RF_LAT = 1;
`endif

   iq_mix_cic_decim dut (
      .clk       (clk),
      .rst       (rst),
      .rf_in     (rf_in),
      .sin_in    (sin_in),
      .cos_in    (cos_in),
      .i_out     (i_out),
      .q_out     (q_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
      edge_cnt++;
      if (tog) rf_in = ~rf_in;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      edge_cnt = 0;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         step();
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // First output sample = int3 after 256 updates, with the first m products at -1
   // (rf_q still 0 from reset) and +1 afterwards.
   function automatic logic [11:0] first_sample(input int m);
      logic [25:0] a1, a2, a3;
      a1 = '0; a2 = '0; a3 = '0;
      for (int k = 0; k < 256; k++) begin
         a3 = a3 + a2;
         a2 = a2 + a1;
         a1 = (k < m) ? a1 - 26'd1 : a1 + 26'd1;
      end
      return a3[25:14];
   endfunction

   initial begin
      bit   ok;
      int   n_ovr, n_low;
      exp_t e;
      logic [11:0] exp_first;

      vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 12'd1024, 12'd1024};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'hC00,  12'hC00};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 12'd0,    12'd0};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 12'd1024, 12'hC00};

      step();
      step();
      rf_in = 1'b1; sin_in = 1'b1; cos_in = 1'b1;
      do_reset();
      chk("reset i_out", i_out, 0);
      chk("reset q_out", q_out, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset overrun", overrun, 0);

      for (int v = 0; v < 4; v++) begin
         tog = vecs[v].tg;
         rf_in = vecs[v].rf; sin_in = vecs[v].s; cos_in = vecs[v].c;
         out_ready = 1'b1;
         do_reset();
         for (int k = 0; k < 3; k++) sb.push_back('{vecs[v].ei, vecs[v].eq});
         for (int s = 1; s <= 6; s++) begin
            wait_valid(300, ok);
            chk($sformatf("vec%0d sample%0d arrives", v, s), ok, 1);
            if (!ok) break;
            if (s == 1) chk($sformatf("vec%0d first latency", v), edge_cnt, 260);
            if (s >= 4) begin
               e = sb.pop_front();
               chk($sformatf("vec%0d s%0d i_out", v, s), i_out, e.i);
               chk($sformatf("vec%0d s%0d q_out", v, s), q_out, e.q);
            end
         end
         sb.delete();
      end
      tog = 1'b0;

      // Overrun: hold ready low across two arrivals
      rf_in = 1'b1; sin_in = 1'b1; cos_in = 1'b1; out_ready = 1'b1;
      do_reset();
      for (int s = 0; s < 4; s++) wait_valid(300, ok);
      chk("ovr setup steady sample", ok, 1);
      out_ready = 1'b0;
      n_ovr = 0; n_low = 0;
      for (int n = 0; n < 255; n++) begin
         step();
         if (overrun) n_ovr++;
         if (!out_valid) n_low++;
      end
      step();
      chk("ovr early pulses", n_ovr, 0);
      chk("ovr valid dropped while pending", n_low, 0);
      chk("ovr pulse on overwrite", overrun, 1);
      chk("ovr valid kept", out_valid, 1);
      chk("ovr new i_out", i_out, 12'd1024);
      step();
      chk("ovr pulse width", overrun, 0);
      chk("ovr valid still pending", out_valid, 1);

      // Ready rises on the overwrite cycle: old sample is accepted, no overrun
      n_ovr = 0;
      for (int n = 0; n < 254; n++) begin
         step();
         if (overrun) n_ovr++;
      end
      out_ready = 1'b1;
      step();
      chk("ready-on-overwrite stray pulses", n_ovr, 0);
      chk("ready-on-overwrite overrun", overrun, 0);
      chk("ready-on-overwrite valid", out_valid, 1);
      step();
      chk("accepted clears valid", out_valid, 0);

      // Mid-period reset discards the pending sample and restarts timing
      out_ready = 1'b0;
      wait_valid(300, ok);
      repeat (100) step();
      chk("pending before reset", out_valid, 1);
      do_reset();
      chk("midrst i_out", i_out, 0);
      chk("midrst q_out", q_out, 0);
      chk("midrst out_valid", out_valid, 0);
      chk("midrst overrun", overrun, 0);
      out_ready = 1'b1;
      wait_valid(400, ok);
      chk("midrst first valid seen", ok, 1);
      chk("midrst first latency", edge_cnt, 260);
      exp_first = first_sample(RF_LAT);
      chk($sformatf("first sample i_out rf latency %0d", RF_LAT), i_out, exp_first);
      chk($sformatf("first sample q_out rf latency %0d", RF_LAT), q_out, exp_first);
      chk("scoreboard drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/iq_mix_cic_decim.md
# iq_mix_cic_decim

Downstream stage of the 1-bit NCO in the 1-bit SDR receive chain. It mixes the 1-bit RF comparator sample with the NCO's 1-bit sin/cos local oscillator into ±1 I/Q products. Each product is decimated through a 3rd-order CIC filter (differential delay 1). Signed OUT_W-bit I/Q samples are delivered at clk/DECIM on a valid/ready handshake to the demodulator.

## Interface
- DECIM, 256, decimation ratio; must be a power of two, at least 4.
- DECIM_LOG2, 8, log2(DECIM); must be consistent with DECIM.
- ACC_W, 26, integrator/comb width; must equal 3*DECIM_LOG2+2.
- OUT_W, 12, output sample width, two's complement.
- clk  input  1  sample clock, same clock that drives the NCO.
- rst  input  1  synchronous reset, active-high.
- rf_in  input  1  comparator/sigma-delta RF bit; 1 means +1, 0 means -1.
- sin_in  input  1  NCO sine bit, same encoding.
- cos_in  input  1  NCO cosine bit, same encoding.
- i_out  output  OUT_W  in-phase sample.
- q_out  output  OUT_W  quadrature sample.
- out_valid  output  1  i_out/q_out hold a sample not yet accepted.
- out_ready  input  1  consumer accepts the sample on a cycle where out_valid && out_ready.
- overrun  output  1  one-cycle pulse when an unaccepted sample is overwritten.

## Operation
- RF path: rf_in is registered to rf_q (see Configuration). sin_in/cos_in are used unregistered.
- Mixer: I product = +1 if rf_q == cos_in, else -1. Q product = +1 if rf_q == sin_in, else -1.
- Integrators, 3 per channel, every clk: int1 += product; int2 += int1; int3 += int2.
  - All arithmetic is ACC_W-bit two's complement.
  - Wrap-around is intended and must not be saturated or flagged.
- Decimation counter dcnt runs 0..DECIM-1 and wraps to 0. A tick is the cycle where dcnt == DECIM-1.
- On a tick, the updated int3 value (registered that cycle) enters the comb pipeline.
- Comb stages, one registered stage each: c1 = x - x_d; c2 = c1 - c1_d; c3 = c2 - c2_d.
  - Each delay register updates only when its stage consumes a new decimated value.
  - Comb arithmetic is modulo 2^ACC_W.
- Output: i_out = c3_I[ACC_W-1 -: OUT_W], q_out = c3_Q[ACC_W-1 -: OUT_W]. Truncation only, no rounding.
- Full-scale DC input gives ±DECIM^3 = ±2^(3*DECIM_LOG2), which maps to ±2^(OUT_W-2). Defaults: ±1024.
- Handshake:
  - A new sample sets out_valid = 1 and loads i_out/q_out.
  - out_valid clears on out_valid && out_ready, unless a new sample lands in the same cycle.
  - A new sample arriving while out_valid && !out_ready overwrites i_out/q_out with the newest sample, pulses overrun, and keeps out_valid = 1.
  - If out_ready is high in that same cycle, the old sample counts as accepted: no overrun.
- Reset: all integrators, combs, delay registers, dcnt, rf_q/synchronizer, i_out, q_out go to 0. out_valid = 0, overrun = 0.
  - A reset asserted mid-frame discards any partial decimation period and any pending sample.

## Timing
- Integrator input: the product uses the rf_q registered in the previous cycle. With the macro defined, rf_in→rf_q latency is 3 cycles; without it, 1 cycle.
- Tick at cycle T: c1 valid at T+1, c2 at T+2, c3 at T+3. i_out/q_out and out_valid are registered at T+4.
- First tick after reset release is DECIM cycles after the first non-reset cycle; the first out_valid follows 4 cycles later.
- The first 3 output samples after reset are CIC transient; steady state is from the 4th sample on.
- Throughput: one I/Q pair per DECIM cycles. out_ready may be held high permanently.

## Configuration
- MIX_RF_SYNC_EN:
  - Defined: rf_in passes through a 2-flop synchronizer before rf_q (3 cycles total). Use this when rf_in comes directly from the asynchronous LVDS comparator.
  - Not defined: a single rf_q register (1 cycle). rf_in is then assumed synchronous to clk.

## Test plan
- rf_in=1, sin_in=1, cos_in=1 (phase_inc 0), out_ready=1 -> from the 4th out_valid on, i_out=1024 and q_out=1024 every 256 cycles.
- rf_in=0, sin_in=1, cos_in=1 -> steady state i_out=-1024 (0xC00), q_out=-1024.
- rf_in toggling every cycle, sin_in=cos_in=1 -> steady state i_out=0, q_out=0. rf_in=1 with cos_in=1, sin_in=0 -> i_out=1024, q_out=-1024.
- out_ready=0 across two ticks -> second sample overwrites the first, one overrun pulse, out_valid stays 1. With out_ready=1 on the overwrite cycle -> no overrun.
- rst for 1 cycle mid-period, then constant inputs -> all outputs 0 and out_valid=0 the cycle after reset. Next out_valid comes exactly 256+4 cycles after reset release; run with and without MIX_RF_SYNC_EN and check the 2-cycle shift in the response.
